// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between execute control and the mul/div unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic             busy;
   logic             done;
   logic             div_zero;
   modport master (output start, op, A, B, input HI, LO, busy, done, div_zero);
   modport slave  (input start, op, A, B, output HI, LO, busy, done, div_zero);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned shift-add multiply / restoring divide with HI/LO registers
module muldiv_unit #(parameter int WIDTH = 32) (
   input  logic           clk,
   input  logic           reset,
   muldiv_unit_if.slave   bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc, acc_nx;
   logic [WIDTH-1:0]   rem, quo, rem_nx, quo_nx;
   logic [WIDTH:0]     msum, sh;
   logic [WIDTH-1:0]   hi, lo;
   logic               dz, ge, last, accept;
   assign accept = (state == IDLE || state == DONE) && bus.start;
   assign last   = cnt == CW'(WIDTH - 1);
   // Multiply: upper half accumulates, lower half holds the multiplier and shifts out.
   always_comb begin
      msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opnd : '0};
      acc_nx = {msum, acc[WIDTH-1:1]};
   end
   // Divide: remainder shifts in dividend bits from quo; quotient bits shift into quo.
   always_comb begin
      sh     = {rem, quo[WIDTH-1]};
      ge     = sh >= {1'b0, opnd};
      rem_nx = ge ? WIDTH'(sh - {1'b0, opnd}) : sh[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], ge};
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = !bus.start ? IDLE : bus.op == 2'b00 ? MUL : bus.op == 2'b01 ? DIV : IDLE;
         MUL:        state_nx = last ? DONE : MUL;
         DIV:        state_nx = last ? DONE : DIV;
         default:    state_nx = IDLE;
      endcase
   end
   always_comb begin
      bus.busy     = state == MUL || state == DIV;
      bus.done     = state == DONE;
      bus.HI       = hi;
      bus.LO       = lo;
      bus.div_zero = dz;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt  <= '0;
         opnd <= '0;
         acc  <= '0;
         rem  <= '0;
         quo  <= '0;
         hi   <= '0;
         lo   <= '0;
         dz   <= 1'b0;
      end else if (accept) begin
         dz  <= 1'b0;
         cnt <= '0;
         case (bus.op)
            2'b00: begin
               opnd <= bus.A;
               acc  <= {{WIDTH{1'b0}}, bus.B};
            end
            2'b01: begin
               opnd <= bus.B;
               quo  <= bus.A;
               rem  <= '0;
            end
            2'b10:   hi <= bus.A;
            default: lo <= bus.A;
         endcase
      end else if (state == MUL) begin
         acc <= acc_nx;
         cnt <= cnt + 1'b1;
         if (last) {hi, lo} <= acc_nx;
      end else if (state == DIV) begin
         rem <= rem_nx;
         quo <= quo_nx;
         cnt <= cnt + 1'b1;
         if (last) begin
            hi <= quo_nx;
            lo <= rem_nx;
            dz <= opnd == '0;
         end
      end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors checked against an arithmetic HI/LO model every cycle
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   int ecnt = 0;
   muldiv_unit_if #(.WIDTH(32)) bus ();
   muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) ecnt++;

   // Model: result is plain arithmetic, released 32 edges after acceptance.
   int          m_cnt = 0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        m_dz = 1'b0, p_dz = 1'b0, m_done = 1'b0;
   longint unsigned prod;
   always @(posedge clk or posedge reset)
      if (reset) begin
         m_cnt = 0; m_hi = '0; m_lo = '0; m_dz = 1'b0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1;
            end
         end else if (bus.start) begin
            m_dz = 1'b0;
            case (bus.op)
               2'b00: begin
                  prod = longint'(bus.A) * longint'(bus.B);
                  p_hi = prod[63:32]; p_lo = prod[31:0]; p_dz = 1'b0; m_cnt = 32;
               end
               2'b01: begin
                  p_dz = bus.B == 0;
                  p_hi = p_dz ? 32'hFFFF_FFFF : bus.A / bus.B;
                  p_lo = p_dz ? bus.A : bus.A % bus.B;
                  m_cnt = 32;
               end
               2'b10: m_hi = bus.A;
               default: m_lo = bus.A;
            endcase
         end
      end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (!reset) begin
         check("busy", bus.busy, m_cnt > 0);
         check("done", bus.done, m_done);
         check("hi", bus.HI, m_hi);
         check("lo", bus.LO, m_lo);
         check("div_zero", bus.div_zero, m_dz);
      end

   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt, output int acc_edge);
      bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
      @(posedge clk); #1;
      acc_edge = ecnt;
      bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
      bcnt = int'(bus.busy);
      lat = 0;
      while (lat < 40 && !bus.done) begin
         @(posedge clk); #1;
         lat++;
         if (bus.busy) bcnt++;
      end
   endtask

   task automatic mv(input logic [1:0] o, input logic [31:0] a);
      bus.start = 1'b1; bus.op = o; bus.A = a;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   int lat, bcnt, e0, e1, ndone;
   initial begin
      bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hi", bus.HI, 0);
      check("rst_lo", bus.LO, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_dz", bus.div_zero, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, e0);
      check("mul_lat", lat, 32);
      check("mul_busy_cycles", bcnt, 32);
      check("mul_hi", bus.HI, 32'hFFFF_FFFE);
      check("mul_lo", bus.LO, 32'h0000_0001);
      @(posedge clk); #1;
      do_op(2'b01, 100, 7, lat, bcnt, e0);
      check("div_lat", lat, 32);
      check("div_hi", bus.HI, 14);
      check("div_lo", bus.LO, 2);
      check("div_dz", bus.div_zero, 0);
      @(posedge clk); #1;
      do_op(2'b01, 5, 0, lat, bcnt, e0);
      check("dz_hi", bus.HI, 32'hFFFF_FFFF);
      check("dz_lo", bus.LO, 5);
      check("dz_flag", bus.div_zero, 1);
      mv(2'b10, 32'h1234);
      check("mv_hi", bus.HI, 32'h1234);
      check("mv_dz_clr", bus.div_zero, 0);
      check("mv_busy", bus.busy, 0);
      // A divide request arriving mid-multiply must be dropped.
      bus.start = 1'b1; bus.op = 2'b00; bus.A = 3; bus.B = 4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.op = 2'b01; bus.A = 9; bus.B = 3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      check("ovl_done_pulses", ndone, 1);
      check("ovl_hi", bus.HI, 0);
      check("ovl_lo", bus.LO, 12);
      mv(2'b10, 32'hAAAA);
      mv(2'b11, 32'h5555);
      check("pre_hi", bus.HI, 32'hAAAA);
      check("pre_lo", bus.LO, 32'h5555);
      bus.start = 1'b1; bus.op = 2'b00; bus.A = 5; bus.B = 5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_hi", bus.HI, 0);
      check("arst_lo", bus.LO, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_done", bus.done, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) ndone++;
      end
      check("arst_idle_after", ndone, 0);
      do_op(2'b00, 6, 7, lat, bcnt, e0);
      check("b2b_mul_lo", bus.LO, 42);
      check("b2b_mul_hi", bus.HI, 0);
      do_op(2'b01, 42, 6, lat, bcnt, e1);
      check("b2b_accept_edge", e1 - e0, 33);
      check("b2b_done_edge", e1 - e0 + lat, 65);
      check("b2b_div_hi", bus.HI, 7);
      check("b2b_div_lo", bus.LO, 0);
      @(posedge clk); #1;
      check("b2b_done_clear", bus.done, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit with architectural HI/LO registers, sitting beside the execute-stage ALU. It takes the mul/div work off the combinational ALU path. It accepts an operation from the decode/execute control and runs a 32-cycle shift-add multiply or restoring divide. It then holds the results in HI/LO for the move-from-HI/LO datapath, and drives `busy` so the pipeline control can stall dependent instructions.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  operation code:
  - 00: multiply unsigned.
  - 01: divide unsigned.
  - 10: move A to HI.
  - 11: move A to LO.
- `A`  in  WIDTH  first operand (multiplicand / dividend / move source).
- `B`  in  WIDTH  second operand (multiplier / divisor).
- `HI`  out  WIDTH  upper product, or quotient.
- `LO`  out  WIDTH  lower product, or remainder.
- `busy`  out  1  high while an iteration is in progress.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated by mul/div.
- `div_zero`  out  1  set when a divide completes with B == 0; cleared by the next accepted start.

## Operation
- States:
  - IDLE: waiting for a request.
  - MUL: multiply iterations.
  - DIV: divide iterations.
  - DONE: results written, `done` high.
- IDLE/DONE with `start`=1:
  - op 00: latch A, B; clear the internal accumulator and iteration counter; go to MUL.
  - op 01: latch A, B; clear the internal accumulator and iteration counter; go to DIV.
  - op 10: HI <= A at the same edge; go to IDLE; no `done` pulse.
  - op 11: LO <= A at the same edge; go to IDLE; no `done` pulse.
- Without `start`, DONE always returns to IDLE.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator. After the WIDTH-th step: {HI,LO} <= full 64-bit product; go to DONE.
- DIV: one restoring step per cycle (shift remainder, trial subtract B, set quotient bit). After the WIDTH-th step: HI <= quotient, LO <= remainder; go to DONE.
- Divide by zero runs the full WIDTH steps. Result: HI = all ones, LO = A, `div_zero` <= 1.
- `div_zero` is cleared on any accepted start, including moves.
- `start` in MUL or DIV is ignored; no queueing; latched operands are unaffected.
- HI/LO change only at completion or on a move. They never show partial results during iteration.
- All arithmetic is unsigned. The product uses the full 2*WIDTH bits with no overflow. No signed variants.

## Timing
- Reset (asynchronous, immediate): state IDLE, HI = 0, LO = 0, `busy` = 0, `done` = 0, `div_zero` = 0, counter = 0.
- Reset mid-operation aborts the operation; no result is written.
- Call the edge that accepts a mul/div start edge 0.
  - `busy` = 1 from after edge 0 through edge WIDTH.
  - Iterations occur on edges 1..WIDTH.
  - HI/LO are updated at edge WIDTH.
  - `done` = 1 for the single cycle between edges WIDTH and WIDTH+1.
- `busy` and `done` are never high together. `busy` is a pure decode of MUL/DIV; `done` is a pure decode of DONE.
- Back-to-back: `start` held in the DONE cycle is accepted at edge WIDTH+1. The new operation gets `busy` from the next cycle, so the sustained rate is WIDTH+1 cycles per operation.
- Moves take effect at the accepting edge. HI/LO are readable the following cycle. `busy` stays 0.
- Operands A, B need to be valid only in the accepting cycle.

## Test plan
- Multiply: A=0xFFFFFFFF, B=0xFFFFFFFF, op 00. Require:
  - `busy` high for 32 cycles.
  - `done` one cycle, 32 cycles after the accept edge.
  - HI=0xFFFFFFFE, LO=0x00000001.
- Divide: A=100, B=7, op 01. Require HI=14, LO=2, `div_zero`=0, `done` at +32.
- Divide by zero: A=5, B=0. Require HI=0xFFFFFFFF, LO=5, `div_zero`=1.
  - A following op 10 with A=0x1234 then gives HI=0x1234 and `div_zero`=0.
- Busy overlap: start multiply 3*4, then pulse start op 01 (A=9, B=3) at cycle 5. Require:
  - The divide is ignored.
  - HI=0, LO=12 at completion.
  - Exactly one `done` pulse.
- Reset mid-op: preload HI/LO via moves (0xAAAA, 0x5555), start multiply, assert `reset` at cycle 10. Require:
  - All outputs 0 immediately.
  - State IDLE.
  - No `done` afterwards.
- Back-to-back: multiply 6*7, then divide 42/6 with start held in the DONE cycle. Require:
  - First result LO=42, HI=0.
  - Second accepted at edge 33.
  - Second result HI=7, LO=0, with `done` at edge 65.
